// File: rtl/sd_word_scanner_pkg.sv
// Shared types, ASCII range constants and character helpers for the
// SD word scanner. Tag-compare case folding is controlled by the
// SCAN_CASE_FOLD_EN macro in tag_matcher; helpers here are always present.
package sd_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SEEK  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } scan_state_t;

  localparam logic [7:0] ASCII_UC_A     = 8'h41;
  localparam logic [7:0] ASCII_UC_Z     = 8'h5A;
  localparam logic [7:0] ASCII_LC_A     = 8'h61;
  localparam logic [7:0] ASCII_LC_Z     = 8'h7A;
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

  // Only A-Z and a-z are letters; digits and punctuation are separators.
  function automatic logic is_letter(input logic [7:0] c);
    return ((c >= ASCII_UC_A) && (c <= ASCII_UC_Z)) ||
           ((c >= ASCII_LC_A) && (c <= ASCII_LC_Z));
  endfunction

  // Fold a-z to A-Z, leave everything else untouched.
  function automatic logic [7:0] fold_upper(input logic [7:0] c);
    logic [7:0] r;
    r = c;
    if ((c >= ASCII_LC_A) && (c <= ASCII_LC_Z)) r = c & ~ASCII_CASE_BIT;
    return r;
  endfunction

endpackage

// File: rtl/sd_word_scanner_if.sv
// Byte-stream handshake between the SD SRAM reader and the scanner.
interface sd_word_scanner_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/sd_word_scanner_tag_matcher.sv
// 8-byte shift window with tag compare. The match output looks at the
// window as it will be after the current shift, so it flags the byte that
// completes the tag in the same cycle that byte is accepted.
// Optional feature macro: SCAN_CASE_FOLD_EN (case-insensitive compare).
module tag_matcher
  import sd_scan_pkg::*;
#(
  parameter logic [63:0] TAG = "DLAB_TAG"
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_clr,
  input  logic       i_shift,
  input  logic [7:0] i_data,
  output logic       o_match
);

  logic [63:0] r_window;
  logic [63:0] w_next;
  logic        w_equal;

  // Newest byte enters at the LSB so the window reads like the tag string.
  assign w_next = {r_window[55:0], i_data};

  // Bytewise compare of the post-shift window against the tag.
  always_comb begin
    w_equal = 1'b1;
    for (int i = 0; i < 8; i++) begin
`ifdef SCAN_CASE_FOLD_EN
      if (fold_upper(w_next[i*8 +: 8]) != fold_upper(TAG[i*8 +: 8])) w_equal = 1'b0;
`else
      if (w_next[i*8 +: 8] != TAG[i*8 +: 8]) w_equal = 1'b0;
`endif
    end
  end

  assign o_match = i_shift && w_equal;

  // Window register: clear wins over shift.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_window <= '0;
    end else if (i_clr) begin
      r_window <= '0;
    end else if (i_shift) begin
      r_window <= w_next;
    end
  end

endmodule

// File: rtl/sd_word_scanner.sv
// SD word scanner: finds TAG_START in the byte stream, then counts words of
// WORD_MIN..WORD_MAX letters until TAG_END completes.
// Optional feature macro: SCAN_CASE_FOLD_EN (case-insensitive tag compare).
//
//   state    | meaning
//   ---------+-------------------------------------------------------
//   ST_IDLE  | waiting for start, stream not accepted
//   ST_SEEK  | accepting bytes, looking for the start tag
//   ST_COUNT | accepting bytes, counting words, looking for end tag
//   ST_DONE  | scan finished, count held until next start
module sd_word_scanner
  import sd_scan_pkg::*;
#(
  parameter logic [63:0] TAG_START = "DLAB_TAG",
  parameter logic [63:0] TAG_END   = "DLAB_END",
  parameter int          WORD_MIN  = 3,
  parameter int          WORD_MAX  = 3,
  parameter int          CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  sd_word_scanner_if.slave   s_in,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   count,
  output logic               overflow
);

  // Run length saturates one past WORD_MAX so over-long words never qualify.
  localparam int             RUN_W   = $clog2(WORD_MAX + 2);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(WORD_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MIN = RUN_W'(WORD_MIN);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WORD_MAX);

  scan_state_t       r_state;
  scan_state_t       w_state_next;
  logic [RUN_W-1:0]  r_run;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;

  logic w_ready;
  logic w_accept;
  logic w_start_cmd;
  logic w_letter;
  logic w_shift_start;
  logic w_shift_end;
  logic w_start_match;
  logic w_end_match;
  logic w_run_ok;

  assign w_ready       = (r_state == ST_SEEK) || (r_state == ST_COUNT);
  assign w_accept      = s_in.in_valid && w_ready;
  assign w_start_cmd   = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_letter      = is_letter(s_in.in_data);
  assign w_shift_start = w_accept && (r_state == ST_SEEK);
  assign w_shift_end   = w_accept && (r_state == ST_COUNT);
  assign w_run_ok      = (r_run >= RUN_MIN) && (r_run <= RUN_MAX);

  tag_matcher #(.TAG(TAG_START)) u_start_tag (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_start_cmd),
    .i_shift (w_shift_start),
    .i_data  (s_in.in_data),
    .o_match (w_start_match)
  );

  tag_matcher #(.TAG(TAG_END)) u_end_tag (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_start_cmd),
    .i_shift (w_shift_end),
    .i_data  (s_in.in_data),
    .o_match (w_end_match)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state logic; start is only honoured from IDLE or DONE.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE,
      ST_DONE:  if (start)         w_state_next = ST_SEEK;
      ST_SEEK:  if (w_start_match) w_state_next = ST_COUNT;
      ST_COUNT: if (w_end_match)   w_state_next = ST_DONE;
      default:                     w_state_next = ST_IDLE;
    endcase
  end

  // Run length and saturating word counter, updated only on accepted bytes
  // in COUNT. The byte completing the end tag drops the run in progress.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_run      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_start_cmd) begin
      r_run      <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (w_shift_end) begin
      if (w_end_match) begin
        r_run <= '0;
      end else if (w_letter) begin
        if (r_run != RUN_SAT) r_run <= r_run + RUN_W'(1);
      end else begin
        r_run <= '0;
        if (w_run_ok) begin
          if (&r_count) r_overflow <= 1'b1;
          else          r_count    <= r_count + CNT_W'(1);
        end
      end
    end
  end

  assign s_in.in_ready = w_ready;
  assign busy          = w_ready;
  assign done          = (r_state == ST_DONE);
  assign count         = r_count;
  assign overflow      = r_overflow;

endmodule

// File: tb/tb_sd_word_scanner.sv
// Bench for sd_word_scanner: three instances (default, WORD 2..5, CNT_W=2)
// see the same byte stream; results are compared with a string-level model.
module tb_sd_word_scanner;

  localparam string TAG_S = "DLAB_TAG";
  localparam string TAG_E = "DLAB_END";
  localparam string BASIC = "xxDLAB_TAG the cat ran.DLAB_END";
  localparam string W25   = "DLAB_TAGa bb ccccc dddddd DLAB_END";

  logic       clk      = 1'b0;
  logic       reset_n  = 1'b0;
  logic       start    = 1'b0;
  logic       tb_valid = 1'b0;
  logic [7:0] tb_data  = 8'h00;

  always #5 clk = ~clk;

  sd_word_scanner_if if_def ();
  sd_word_scanner_if if_w25 ();
  sd_word_scanner_if if_c2 ();

  assign if_def.in_valid = tb_valid;
  assign if_def.in_data  = tb_data;
  assign if_w25.in_valid = tb_valid;
  assign if_w25.in_data  = tb_data;
  assign if_c2.in_valid  = tb_valid;
  assign if_c2.in_data   = tb_data;

  logic        busy_def, done_def, ovf_def;
  logic [15:0] cnt_def;
  logic        busy_w25, done_w25, ovf_w25;
  logic [15:0] cnt_w25;
  logic        busy_c2, done_c2, ovf_c2;
  logic [1:0]  cnt_c2;

  sd_word_scanner u_def (
    .clk(clk), .reset_n(reset_n), .start(start), .s_in(if_def.slave),
    .busy(busy_def), .done(done_def), .count(cnt_def), .overflow(ovf_def));

  sd_word_scanner #(.WORD_MIN(2), .WORD_MAX(5)) u_w25 (
    .clk(clk), .reset_n(reset_n), .start(start), .s_in(if_w25.slave),
    .busy(busy_w25), .done(done_w25), .count(cnt_w25), .overflow(ovf_w25));

  sd_word_scanner #(.CNT_W(2)) u_c2 (
    .clk(clk), .reset_n(reset_n), .start(start), .s_in(if_c2.slave),
    .busy(busy_c2), .done(done_c2), .count(cnt_c2), .overflow(ovf_c2));

  int n_pass  = 0;
  int n_total = 0;

  function automatic bit tag_eq(input string a, input string b);
`ifdef SCAN_CASE_FOLD_EN
    return a.toupper() == b.toupper();
`else
    return a == b;
`endif
  endfunction

  function automatic bit alpha(input byte c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  // Reference: locate the tags by substring search, then count letter runs
  // that are terminated by a non-letter strictly before the end tag's last byte.
  function automatic void model(input string s, input int mn, input int mx,
                                input int cw, output int cnt, output bit ovf,
                                output bit fin);
    int st, en, run, maxc;
    st = -1; en = -1; run = 0; maxc = (1 << cw) - 1;
    cnt = 0; ovf = 0; fin = 0;
    for (int i = 7; i < s.len(); i++)
      if (st < 0 && tag_eq(s.substr(i-7, i), TAG_S)) st = i + 1;
    if (st < 0) return;
    for (int j = st + 7; j < s.len(); j++)
      if (en < 0 && tag_eq(s.substr(j-7, j), TAG_E)) en = j;
    if (en < 0) return;
    fin = 1;
    for (int k = st; k < en; k++) begin
      if (alpha(s[k])) run++;
      else begin
        if (run >= mn && run <= mx) begin
          if (cnt == maxc) ovf = 1;
          else cnt++;
        end
        run = 0;
      end
    end
  endfunction

  function automatic string chr(input byte b);
    string r;
    r = " ";
    r.putc(0, b);
    return r;
  endfunction

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); reset_n = 1'b0; tb_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic send_str(input string s, input int stall_pct);
    for (int i = 0; i < s.len(); i++) begin
      if (stall_pct > 0 && int'($urandom_range(99, 0)) < stall_pct) begin
        @(negedge clk); tb_valid = 1'b0;
      end
      @(negedge clk); tb_valid = 1'b1; tb_data = s[i];
    end
    @(negedge clk); tb_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy_def, done_def, ovf_def, cnt_def, if_def.in_ready} !== 20'h0) begin
      $display("FAIL reset_state got=%h want=0", {busy_def, done_def, ovf_def, cnt_def, if_def.in_ready});
    end else n_pass++;
    reset_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (busy_def !== 1'b0 || if_def.in_ready !== 1'b0) begin
      $display("FAIL idle_no_ready busy=%b ready=%b want 0", busy_def, if_def.in_ready);
    end else n_pass++;
  endtask

  task automatic test_basic();
    int ec; bit eo, ef;
    do_start();
    n_total++;
    if (busy_def !== 1'b1 || if_def.in_ready !== 1'b1) begin
      $display("FAIL seek_ready busy=%b ready=%b want 1", busy_def, if_def.in_ready);
    end else n_pass++;
    send_str(BASIC, 0);
    n_total++;
    if ({done_def, ovf_def, cnt_def} !== {1'b1, 1'b0, 16'd3}) begin
      $display("FAIL basic_def done=%b ovf=%b cnt=%0d want 1 0 3", done_def, ovf_def, cnt_def);
    end else n_pass++;
    model(BASIC, 2, 5, 16, ec, eo, ef);
    n_total++;
    if ({done_w25, ovf_w25, cnt_w25} !== {ef, eo, 16'(ec)}) begin
      $display("FAIL basic_w25 done=%b ovf=%b cnt=%0d want %b %b %0d", done_w25, ovf_w25, cnt_w25, ef, eo, ec);
    end else n_pass++;
    n_total++;
    if ({busy_def, busy_w25, busy_c2, if_def.in_ready, if_w25.in_ready, if_c2.in_ready, done_c2} !== 7'b0000001) begin
      $display("FAIL done_outputs got=%b want=0000001",
               {busy_def, busy_w25, busy_c2, if_def.in_ready, if_w25.in_ready, if_c2.in_ready, done_c2});
    end else n_pass++;
  endtask

  task automatic test_word_range();
    do_start();
    send_str(W25, 0);
    n_total++;
    if ({done_w25, cnt_w25} !== {1'b1, 16'd3}) begin
      $display("FAIL w25_count done=%b cnt=%0d want 1 3", done_w25, cnt_w25);
    end else n_pass++;
    n_total++;
    if (cnt_def !== 16'd0) begin
      $display("FAIL w25_def_count cnt=%0d want 0", cnt_def);
    end else n_pass++;
  endtask

  task automatic test_stall();
    bit ready_bad;
    ready_bad = 0;
    do_start();
    for (int i = 0; i < BASIC.len(); i++) begin
      @(negedge clk); tb_valid = 1'b1; tb_data = BASIC[i];
      @(negedge clk); tb_valid = 1'b0;
      if (i != BASIC.len() - 1 && if_def.in_ready !== 1'b1) ready_bad = 1;
    end
    n_total++;
    if (ready_bad) begin
      $display("FAIL stall_ready ready dropped during stall, want held high");
    end else n_pass++;
    n_total++;
    if ({done_def, cnt_def} !== {1'b1, 16'd3}) begin
      $display("FAIL stall_count done=%b cnt=%0d want 1 3", done_def, cnt_def);
    end else n_pass++;
  endtask

  task automatic test_saturate();
    do_start();
    send_str("DLAB_TAG abc def ghi jkl mno DLAB_END", 0);
    n_total++;
    if ({done_c2, ovf_c2, cnt_c2} !== {1'b1, 1'b1, 2'd3}) begin
      $display("FAIL sat_c2 done=%b ovf=%b cnt=%0d want 1 1 3", done_c2, ovf_c2, cnt_c2);
    end else n_pass++;
    n_total++;
    if ({ovf_def, cnt_def} !== {1'b0, 16'd5}) begin
      $display("FAIL sat_def ovf=%b cnt=%0d want 0 5", ovf_def, cnt_def);
    end else n_pass++;
  endtask

  task automatic test_reset_mid();
    do_start();
    send_str("xxDLAB_TAG the ca", 0);
    n_total++;
    if ({busy_def, cnt_def} !== {1'b1, 16'd1}) begin
      $display("FAIL mid_precond busy=%b cnt=%0d want 1 1", busy_def, cnt_def);
    end else n_pass++;
    reset_n = 1'b0;
    #1;
    n_total++;
    if ({busy_def, done_def, ovf_def, cnt_def, if_def.in_ready} !== 20'h0) begin
      $display("FAIL mid_async_reset got=%h want=0", {busy_def, done_def, ovf_def, cnt_def, if_def.in_ready});
    end else n_pass++;
    @(negedge clk); reset_n = 1'b1;
    send_str("t ran.", 0);
    n_total++;
    if ({busy_def, cnt_def} !== {1'b0, 16'd0}) begin
      $display("FAIL mid_no_restart busy=%b cnt=%0d want 0 0", busy_def, cnt_def);
    end else n_pass++;
    do_start();
    send_str(BASIC, 0);
    n_total++;
    if ({done_def, cnt_def} !== {1'b1, 16'd3}) begin
      $display("FAIL mid_rescan done=%b cnt=%0d want 1 3", done_def, cnt_def);
    end else n_pass++;
  endtask

  task automatic test_case_fold();
    int ec; bit eo, ef;
    string s;
    s = "dlab_tag abc DLAB_END";
    model(s, 3, 3, 16, ec, eo, ef);
    do_start();
    send_str(s, 0);
    n_total++;
    if ({done_def, busy_def, cnt_def} !== {ef, ~ef, 16'(ec)}) begin
      $display("FAIL case_fold done=%b busy=%b cnt=%0d want %b %b %0d", done_def, busy_def, cnt_def, ef, ~ef, ec);
    end else n_pass++;
    do_reset();
  endtask

  task automatic test_start_ignored();
    do_start();
    send_str("xxDLAB_TAG the cat", 0);
    do_start();
    send_str(" ran.DLAB_END", 0);
    n_total++;
    if ({done_def, cnt_def} !== {1'b1, 16'd3}) begin
      $display("FAIL start_ignored done=%b cnt=%0d want 1 3", done_def, cnt_def);
    end else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ec; bit eo, ef;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); tb_valid = 1'b1; tb_data = 8'h20;
    end
    @(negedge clk); tb_valid = 1'b0;
    n_total++;
    if ({done_def, cnt_def} !== {1'b1, 16'd3}) begin
      $display("FAIL done_hold done=%b cnt=%0d want 1 3", done_def, cnt_def);
    end else n_pass++;
    do_start();
    n_total++;
    if ({done_def, busy_def, cnt_def} !== {1'b0, 1'b1, 16'd0}) begin
      $display("FAIL restart_clear done=%b busy=%b cnt=%0d want 0 1 0", done_def, busy_def, cnt_def);
    end else n_pass++;
    send_str(W25, 0);
    model(W25, 3, 3, 16, ec, eo, ef);
    n_total++;
    if ({done_def, cnt_def} !== {ef, 16'(ec)}) begin
      $display("FAIL b2b_def done=%b cnt=%0d want %b %0d", done_def, cnt_def, ef, ec);
    end else n_pass++;
  endtask

  task automatic test_random();
    string s, seps, pre;
    int ec, nw, wl;
    bit eo, ef;
    seps = " .,09-";
    pre  = "xyz .9";
    for (int it = 0; it < 20; it++) begin
      s = "";
      for (int p = 0; p < int'($urandom_range(3, 0)); p++)
        s = {s, chr(pre[$urandom_range(pre.len() - 1, 0)])};
      s = {s, TAG_S};
      nw = $urandom_range(8, 0);
      for (int w = 0; w < nw; w++) begin
        wl = $urandom_range(7, 1);
        for (int l = 0; l < wl; l++)
          s = {s, chr(8'($urandom_range(25, 0)) + ($urandom_range(1, 0) ? 8'h41 : 8'h61))};
        if (w != nw - 1 || $urandom_range(1, 0) == 1) begin
          for (int q = 0; q < int'($urandom_range(2, 1)); q++)
            s = {s, chr(seps[$urandom_range(seps.len() - 1, 0)])};
        end
      end
      s = {s, TAG_E};
      do_start();
      send_str(s, 30);
      model(s, 3, 3, 16, ec, eo, ef);
      n_total++;
      if ({done_def, ovf_def, cnt_def} !== {ef, eo, 16'(ec)}) begin
        $display("FAIL rand_def it=%0d got %b %b %0d want %b %b %0d", it, done_def, ovf_def, cnt_def, ef, eo, ec);
      end else n_pass++;
      model(s, 2, 5, 16, ec, eo, ef);
      n_total++;
      if ({done_w25, ovf_w25, cnt_w25} !== {ef, eo, 16'(ec)}) begin
        $display("FAIL rand_w25 it=%0d got %b %b %0d want %b %b %0d", it, done_w25, ovf_w25, cnt_w25, ef, eo, ec);
      end else n_pass++;
      model(s, 3, 3, 2, ec, eo, ef);
      n_total++;
      if ({done_c2, ovf_c2, cnt_c2} !== {ef, eo, 2'(ec)}) begin
        $display("FAIL rand_c2 it=%0d got %b %b %0d want %b %b %0d", it, done_c2, ovf_c2, cnt_c2, ef, eo, ec);
      end else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_word_range();
    test_stall();
    test_saturate();
    test_reset_mid();
    test_back_to_back();
    test_start_ignored();
    test_case_fold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
